// File: rtl/divider_16bit_seq_if.sv
// Handshake bundle for the sequential divider: operand request channel and result channel.
interface divider_16bit_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider_16bit_seq.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// Divide-by-zero short-circuits to DONE with quotient all-ones and remainder = dividend.
module divider_16bit_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    divider_16bit_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_divisor;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dbz;

    logic             w_accept;
    logic             w_last;
    logic             w_dvs_zero;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;

    assign w_accept   = bus.in_valid && (r_state == IDLE);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_dvs_zero = (bus.divisor == '0);

    // r_quot starts out holding the dividend; its MSB feeds the partial remainder
    // while quotient bits shift in at the LSB end.
    assign w_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_divisor};
    assign w_qbit  = ~w_diff[WIDTH];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_dvs_zero ? DONE : CALC;
            CALC:    if (w_last) w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_dbz     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_divisor <= bus.divisor;
                        r_cnt     <= '0;
                        if (w_dvs_zero) begin
                            r_quot <= '1;
                            r_rem  <= bus.dividend;
                            r_dbz  <= 1'b1;
                        end else begin
                            r_quot <= bus.dividend;
                            r_rem  <= '0;
                            r_dbz  <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    r_rem  <= w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                    r_quot <= {r_quot[WIDTH-2:0], w_qbit};
                    r_cnt  <= r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (r_state == IDLE);
    assign bus.out_valid   = (r_state == DONE);
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_divider_16bit_seq.sv
// Directed and randomized checks of the sequential divider: latency, results,
// divide-by-zero, backpressure hold, handoff rules and reset abort.
module tb_divider_16bit_seq;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    divider_16bit_seq_if #(.WIDTH(16)) bus ();

    divider_16bit_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_quotient"}, 32'(bus.quotient), 32'd0);
        chk({tag, "_remainder"}, 32'(bus.remainder), 32'd0);
        chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'd0);
    endtask

    // One full transaction; elat = rising edges after the accepting edge before out_valid is seen.
    task automatic run_op(input logic [15:0] dvd, input logic [15:0] dvs,
                          input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                          input int elat, input int hold, input bit toggle);
        int lat;
        @(negedge clk);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.dividend  = dvd;
        bus.divisor   = dvs;
        bus.out_ready = (hold == 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 16'($urandom);
        if (elat > 0) chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (toggle) begin
                bus.in_valid = ~bus.in_valid;
                bus.dividend = 16'($urandom);
            end
        end
        chk("latency", 32'(lat), 32'(elat));
        chk("quotient", 32'(bus.quotient), 32'(eq));
        chk("remainder", 32'(bus.remainder), 32'(er));
        chk("div_by_zero", 32'(bus.div_by_zero), 32'(edbz));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (toggle) begin
                bus.in_valid = ~bus.in_valid;
                bus.dividend = 16'($urandom);
                bus.divisor  = 16'($urandom);
            end
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_quotient", 32'(bus.quotient), 32'(eq));
            chk("hold_remainder", 32'(bus.remainder), 32'(er));
            chk("hold_dbz", 32'(bus.div_by_zero), 32'(edbz));
        end
        bus.out_ready = 1'b1;
        if (toggle) bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("handoff_in_ready", 32'(bus.in_ready), 32'd1);
        chk("handoff_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int           saw;
        logic [15:0]  rd;
        logic [15:0]  rs;
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;

        #3;
        chk_reset_outputs("reset");
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

        // Release just after a rising edge so the first accept uses the very next edge.
        @(posedge clk);
        #2 rst_n = 1'b1;

        run_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 16, 0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16, 0, 1'b0);
        run_op(16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 16, 0, 1'b0);
        run_op(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 0, 0, 1'b0);
        run_op(16'd0, 16'd0, 16'hFFFF, 16'd0, 1'b1, 0, 2, 1'b0);
        run_op(16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 16, 0, 1'b0);
        run_op(16'h8000, 16'h0002, 16'h4000, 16'h0000, 1'b0, 16, 1, 1'b0);
        run_op(16'hFFFF, 16'h00FF, 16'h0101, 16'h0000, 1'b0, 16, 0, 1'b0);
        run_op(16'd12345, 16'h0100, 16'd48, 16'd57, 1'b0, 16, 0, 1'b0);
        run_op(16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 16, 10, 1'b1);

        // Abort an operation 8 cycles into CALC.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.dividend  = 16'd500;
        bus.divisor   = 16'd3;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        saw = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) saw++;
        end
        chk("abort_no_stale_valid", 32'(saw), 32'd0);
        run_op(16'd200, 16'd9, 16'd22, 16'd2, 1'b0, 16, 0, 1'b0);

        // Randomized operands against a floor/mod reference.
        for (int n = 0; n < 1500; n++) begin
            rd = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       rs = 16'd0;
                1, 2:    rs = 16'($urandom_range(1, 15));
                3:       rs = 16'hFFFF - 16'($urandom_range(0, 3));
                default: rs = 16'($urandom);
            endcase
            if (rs == 16'd0)
                run_op(rd, rs, 16'hFFFF, rd, 1'b1, 0, $urandom_range(0, 2), 1'b0);
            else
                run_op(rd, rs, rd / rs, rd % rs, 1'b0, 16, $urandom_range(0, 2), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
